// File: rtl/inst_queue.sv
// Instruction queue between if_stage and id_stage: a small FIFO of {pc, inst} packets with branch flush.
// Optional macro IQ_BYPASS_EN: an empty queue forwards the incoming fetch packet to decode in the same cycle.
module inst_queue #(
   parameter int DEPTH = 4,
   parameter int BUS_W = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     fs_to_ds_valid,
   input  logic [BUS_W-1:0]         fs_ds_bus,
   output logic                     iq_allow_in,
   input  logic                     ds_allow_in,
   output logic                     iq_to_ds_valid,
   output logic [BUS_W-1:0]         iq_ds_bus,
   input  logic                     br_flush,
   output logic [$clog2(DEPTH):0]   iq_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [BUS_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             empty;
   logic             full;
   logic             push;
   logic             pop;
   logic             q_push;
   logic             q_pop;

   assign empty       = (count == '0);
   assign full        = (count == FULL_CNT);
   // Full refuses outright: no combinational path from ds_allow_in to fetch.
   assign iq_allow_in = !reset && !full;
   assign push        = fs_to_ds_valid && iq_allow_in && !br_flush;
   assign iq_count    = count;

`ifdef IQ_BYPASS_EN
   assign iq_to_ds_valid = (!empty || fs_to_ds_valid) && !br_flush && !reset;
   assign iq_ds_bus      = empty ? fs_ds_bus : mem[rd_ptr];
   assign pop            = iq_to_ds_valid && ds_allow_in;
   // A bypassed packet taken by decode never touches storage.
   assign q_push         = push && !(empty && pop);
   assign q_pop          = pop && !empty;
`else
   assign iq_to_ds_valid = !empty && !br_flush;
   assign iq_ds_bus      = mem[rd_ptr];
   assign pop            = iq_to_ds_valid && ds_allow_in;
   assign q_push         = push;
   assign q_pop          = pop;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (br_flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (q_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (q_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({q_push, q_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Packet storage carries no reset; validity is tracked by count alone.
   always_ff @(posedge clk) begin
      if (q_push) mem[wr_ptr] <= fs_ds_bus;
   end

   always_ff @(posedge clk) begin
      if (!reset && !br_flush) begin
         assert (!(q_push && !q_pop && full));
         assert (!(q_pop && !q_push && empty));
      end
   end

endmodule
